// File: rtl/ram_pipe.sv
// Simple dual-port RAM with byte-lane writes, RD_LAT-stage read pipeline and a post-reset clear sweep.
// Optional build macro RAM_BYPASS_EN selects write-first data on same-edge read/write collisions.
module ram_pipe #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [AWIDTH-1:0]      waddr,
    input  logic [DWIDTH-1:0]      wdata,
    input  logic [DWIDTH/8-1:0]    wbe,
    input  logic                   re,
    input  logic [AWIDTH-1:0]      raddr,
    output logic [DWIDTH-1:0]      rdata,
    output logic                   rvalid,
    output logic                   busy
);
    localparam int BEW   = DWIDTH / 8;
    localparam int DEPTH = 2 ** AWIDTH;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                          state_q, state_d;
    logic [AWIDTH-1:0]               clr_addr_q, clr_addr_d;
    logic [RD_LAT-1:0]               vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][DWIDTH-1:0]   dpipe_q, dpipe_d;

    logic [DWIDTH-1:0]               mem_q [DEPTH];
    logic                            mem_we;
    logic [AWIDTH-1:0]               mem_waddr;
    logic [DWIDTH-1:0]               mem_wdata;
    logic [DWIDTH-1:0]               wr_merged;
    logic [DWIDTH-1:0]               rd_word;
    logic                            rd_acc;

    assign busy   = (state_q == CLEAR);
    assign rd_acc = re && (state_q == IDLE);
    assign rdata  = dpipe_q[RD_LAT-1];
    assign rvalid = vld_pipe_q[RD_LAT-1];

    // Read-modify-write merge keeps disabled lanes at their stored value.
    always_comb begin
        wr_merged = mem_q[waddr];
        for (int k = 0; k < BEW; k++) begin
            if (wbe[k]) wr_merged[8*k +: 8] = wdata[8*k +: 8];
        end
    end

    always_comb begin
        rd_word = mem_q[raddr];
`ifdef RAM_BYPASS_EN
        if (we && (waddr == raddr)) begin
            for (int k = 0; k < BEW; k++) begin
                if (wbe[k]) rd_word[8*k +: 8] = wdata[8*k +: 8];
            end
        end
`endif
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = waddr;
        mem_wdata  = wr_merged;
        case (state_q)
            CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == '1) state_d = IDLE;
            end
            default: begin
                mem_we = we && (wbe != '0);
            end
        endcase
    end

    // Each stage only loads on a valid so the output holds its last result.
    always_comb begin
        vld_pipe_d    = '0;
        dpipe_d       = dpipe_q;
        vld_pipe_d[0] = rd_acc;
        if (rd_acc) dpipe_d[0] = rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            if (vld_pipe_q[i-1]) dpipe_d[i] = dpipe_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
            vld_pipe_q <= '0;
            dpipe_q    <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            vld_pipe_q <= vld_pipe_d;
            dpipe_q    <= dpipe_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

endmodule

// File: tb/tb_ram_pipe.sv
// Scoreboard bench for ram_pipe (AWIDTH=4, DWIDTH=16, RD_LAT=2).
module tb_ram_pipe;
    localparam int AW = 4;
    localparam int DW = 16;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          we = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [1:0]    wbe = '0;
    logic          re = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          busy;

    ram_pipe #(.AWIDTH(AW), .DWIDTH(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: every rvalid must match the oldest expected read, on its exact cycle.
    always @(negedge clk) begin
        if (rvalid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_rvalid cyc=%0d rdata=%h", cyc, rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rdata !== e.data || cyc != e.cyc) begin
                    errors = errors + 1;
                    $display("FAIL read_data cyc=%0d got=%h want=%h at_cyc=%0d", cyc, rdata, e.data, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks = checks + 1;
        if (got !== want) begin
            errors = errors + 1;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic expect_read(input logic [DW-1:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + RL;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        we = 1'b1; waddr = a; wdata = d; wbe = be;
        tick();
        we = 1'b0; wbe = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        re = 1'b1; raddr = a;
        expect_read(d);
        tick();
        re = 1'b0;
    endtask

    task automatic release_and_sweep(input string name);
        int n;
        n = 0;
        rst = 1'b0;
        while (busy && n < 40) begin
            n = n + 1;
            tick();
        end
        checks = checks + 1;
        if (n != 16) begin
            errors = errors + 1;
            $display("FAIL %s busy_cycles got=%0d want=16", name, n);
        end
    endtask

    initial begin
        exp_t dummy;
        logic [DW-1:0] coll;
        repeat (3) tick();
        check("reset_rdata", rdata, 16'h0000);
        check("reset_rvalid", {15'd0, rvalid}, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'h0001);

        // Test 5 + 1: requests during the sweep are ignored; all words read back as zero.
        we = 1'b1; waddr = 4'd2; wdata = 16'hFFFF; wbe = 2'b11;
        re = 1'b1; raddr = 4'd2;
        release_and_sweep("sweep1");
        we = 1'b0; re = 1'b0; wbe = '0;
        for (int i = 0; i < 16; i++) rd(i[AW-1:0], 16'h0000);
        repeat (4) tick();

        // Test 2: back-to-back reads at full throughput.
        for (int i = 0; i < 16; i++) wr(i[AW-1:0], 16'hA500 + i[DW-1:0], 2'b11);
        for (int i = 0; i < 16; i++) begin
            re = 1'b1; raddr = i[AW-1:0];
            expect_read(16'hA500 + i[DW-1:0]);
            tick();
        end
        re = 1'b0;
        repeat (4) tick();

        // Test 3: low-lane-only write.
        wr(4'd3, 16'h1234, 2'b11);
        wr(4'd3, 16'hABCD, 2'b01);
        rd(4'd3, 16'h12CD);
        wr(4'd4, 16'h5678, 2'b11);
        wr(4'd4, 16'h9A00, 2'b10);
        wr(4'd4, 16'hFFFF, 2'b00);
        rd(4'd4, 16'h9A78);
        repeat (3) tick();

        // Test 4: same-edge collision, plus an independent write to another address.
        wr(4'd5, 16'h1111, 2'b11);
`ifdef RAM_BYPASS_EN
        coll = 16'h2222;
`else
        coll = 16'h1111;
`endif
        we = 1'b1; waddr = 4'd5; wdata = 16'h2222; wbe = 2'b11;
        re = 1'b1; raddr = 4'd5;
        expect_read(coll);
        tick();
        waddr = 4'd6; wdata = 16'h6666; raddr = 4'd5;
        expect_read(16'h2222);
        tick();
        we = 1'b0; re = 1'b0; wbe = '0;
        rd(4'd6, 16'h6666);
        repeat (4) tick();

        // Test 6: reset with reads in flight drops them and re-clears memory.
        re = 1'b1; raddr = 4'd7;
        tick();
        raddr = 4'd8;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_rdata", rdata, 16'h0000);
        check("midrst_rvalid", {15'd0, rvalid}, 16'h0000);
        check("midrst_busy", {15'd0, busy}, 16'h0001);
        re = 1'b0;
        tick();
        release_and_sweep("sweep2");
        rd(4'd7, 16'h0000);
        rd(4'd3, 16'h0000);
        rd(4'd5, 16'h0000);
        repeat (5) tick();

        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            dummy = exp_q[0];
            $display("FAIL missing_rvalid pending=%0d first_want=%h", exp_q.size(), dummy.data);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
